// File: rtl/piece_action_scheduler.sv
// rtl/piece_action_scheduler.sv - latches move/gravity/drop requests and issues them one at a time
// Fixed-priority arbiter feeding a valid/ready command port, with a completion wait and timeout abort.
module piece_action_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          game_active,
  input  logic          req_left,
  input  logic          req_right,
  input  logic          req_rotate,
  input  logic          gravity_tick,
  input  logic          req_drop,
  input  logic          cmd_ready,
  input  logic          cmd_done,
  output logic          cmd_valid,
  output logic [2:0]    cmd_code,
  output logic          busy,
  output logic [4:0]    pending,
  output logic          timeout_err
);

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_LEFT   = 3'd1;
  localparam logic [2:0] C_RIGHT  = 3'd2;
  localparam logic [2:0] C_ROTATE = 3'd3;
  localparam logic [2:0] C_DOWN   = 3'd4;
  localparam logic [2:0] C_DROP   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_cnt;
  logic [4:0]      r_pending;
  logic            r_valid;
  logic [2:0]      r_code;
  logic            r_busy;
  logic            r_err;

  logic [4:0]      w_req;
  logic [4:0]      w_clear;
  logic [2:0]      w_win_code;
  logic            w_accept;
  logic            w_cancel;
  logic            w_issue;

  assign w_req    = {req_drop, gravity_tick, req_rotate, req_right, req_left};
  assign w_accept = (r_state == S_ISSUE) && r_valid && cmd_ready;
  // Opposing horizontal moves cancel when nothing higher-priority is waiting.
  assign w_cancel = (r_state == S_IDLE) && game_active &&
                    (r_pending[1:0] == 2'b11) && (r_pending[4:2] == 3'b000);
  assign w_issue  = (r_state == S_IDLE) && game_active && (|r_pending) && !w_cancel;

  always_comb begin
    w_win_code = C_NONE;
    if (r_pending[4])      w_win_code = C_DROP;
    else if (r_pending[3]) w_win_code = C_DOWN;
    else if (r_pending[2]) w_win_code = C_ROTATE;
    else if (r_pending[0]) w_win_code = C_LEFT;
    else if (r_pending[1]) w_win_code = C_RIGHT;
  end

  // Clear uses the latched code so a late higher-priority request cannot retarget the accept.
  always_comb begin
    w_clear = 5'b00000;
    if (w_accept) begin
      case (r_code)
        C_LEFT:   w_clear = 5'b00001;
        C_RIGHT:  w_clear = 5'b00010;
        C_ROTATE: w_clear = 5'b00100;
        C_DOWN:   w_clear = 5'b01000;
        C_DROP:   w_clear = 5'b11111;
        default:  w_clear = 5'b00000;
      endcase
    end
    if (w_cancel) w_clear = 5'b00011;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 5'b00000;
    end else if (!game_active) begin
      r_pending <= 5'b00000;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_code  <= C_NONE;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_issue) begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            r_code  <= w_win_code;
            r_busy  <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_code  <= C_NONE;
            r_busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            r_state <= S_WAIT;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            r_state <= S_IDLE;
            r_code  <= C_NONE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == TW'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_code  <= C_NONE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_code  <= C_NONE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign cmd_valid   = r_valid;
  assign cmd_code    = r_code;
  assign busy        = r_busy;
  assign pending     = r_pending;
  assign timeout_err = r_err;

endmodule
